// File: rtl/spm_port_arbiter.sv
// Shares SPM port B between the MEM stage and a DMA master: MEM has fixed priority and a wait counter forces DMA through.
// Latency: issue cycle plus one response cycle. A requester holds its request until rdy_ is seen, and only IDLE cycles accept a new access.
module spm_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_as_,
  input  logic              mem_rw,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_rdy_,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_as_,
  input  logic              dma_rw,
  input  logic [DATA_W-1:0] dma_wr_data,
  output logic [DATA_W-1:0] dma_rd_data,
  output logic              dma_rdy_,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM_RSP = 2'd1, DMA_RSP = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           r_state;
  logic [CNT_W-1:0] r_dma_wait;
  logic             r_rd;

  logic w_idle, w_mem_win, w_dma_win, w_mem_rsp, w_dma_rsp;

  // Gating with reset_ forces every output to its reset value while reset is held.
  assign w_idle    = reset_ && (r_state == IDLE);
  assign w_dma_win = w_idle && !dma_as_ && (mem_as_ || (r_dma_wait == LIMIT));
  assign w_mem_win = w_idle && !mem_as_ && !w_dma_win;
  assign w_mem_rsp = reset_ && (r_state == MEM_RSP);
  assign w_dma_rsp = reset_ && (r_state == DMA_RSP);

  always_comb begin
    spm_as_     = 1'b1;
    spm_rw      = 1'b1;
    spm_addr    = '0;
    spm_wr_data = '0;
    if (w_mem_win) begin
      spm_as_     = 1'b0;
      spm_rw      = mem_rw;
      spm_addr    = mem_addr;
      spm_wr_data = mem_wr_data;
    end else if (w_dma_win) begin
      spm_as_     = 1'b0;
      spm_rw      = dma_rw;
      spm_addr    = dma_addr;
      spm_wr_data = dma_wr_data;
    end
  end

  assign mem_rdy_    = !w_mem_rsp;
  assign dma_rdy_    = !w_dma_rsp;
  assign mem_rd_data = (w_mem_rsp && r_rd) ? spm_rd_data : '0;
  assign dma_rd_data = (w_dma_rsp && r_rd) ? spm_rd_data : '0;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= IDLE;
      r_dma_wait <= '0;
      r_rd       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dma_win) begin
            r_state    <= DMA_RSP;
            r_rd       <= dma_rw;
            r_dma_wait <= '0;
          end else if (w_mem_win) begin
            r_state <= MEM_RSP;
            r_rd    <= mem_rw;
            if (!dma_as_ && (r_dma_wait != LIMIT))
              r_dma_wait <= r_dma_wait + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Randomized bench for spm_port_arbiter: a sync-RAM model stands in for the SPM, and a cycle-level arbitration model checks every output on each negedge.
module tb_spm_port_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          reset_;
  logic [AW-1:0] mem_addr, dma_addr, spm_addr;
  logic          mem_as_, mem_rw, dma_as_, dma_rw, spm_as_, spm_rw;
  logic [DW-1:0] mem_wr_data, dma_wr_data, spm_wr_data;
  logic [DW-1:0] mem_rd_data, dma_rd_data, spm_rd_data;
  logic          mem_rdy_, dma_rdy_;

  always #5 clk = ~clk;

  spm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_(reset_),
    .mem_addr(mem_addr), .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_rdy_(mem_rdy_),
    .dma_addr(dma_addr), .dma_as_(dma_as_), .dma_rw(dma_rw), .dma_wr_data(dma_wr_data),
    .dma_rd_data(dma_rd_data), .dma_rdy_(dma_rdy_),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  function automatic logic [31:0] init_val(int a);
    if (a == 16) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // SPM port B: synchronous RAM, read data valid the cycle after issue.
  logic [DW-1:0] spm_mem [0:4095];
  bit            spm_wr  [0:4095];
  always @(posedge clk) begin
    if (!spm_as_) begin
      if (spm_rw) spm_rd_data <= spm_wr[spm_addr] ? spm_mem[spm_addr] : init_val(int'(spm_addr));
      else begin
        spm_mem[spm_addr] <= spm_wr_data;
        spm_wr[spm_addr]  <= 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Literal expectations posted by the stimulus for the coming negedge.
  int          lit_cyc = -1;
  int          lit_n   = 0;
  int          lit_sel [0:15];
  logic [31:0] lit_exp [0:15];

  // Reference model state.
  int            m_owner = 0;
  int            m_wait  = 0;
  logic          m_rd;
  logic [AW-1:0] m_addr;
  logic [31:0]   shadow [int];

  function automatic string sel_name(int s);
    case (s)
      0: return "spm_as_";      1: return "spm_rw";
      2: return "spm_addr";     3: return "spm_wr_data";
      4: return "mem_rdy_";     5: return "dma_rdy_";
      6: return "mem_rd_data";  7: return "dma_rd_data";
      default: return "model_wait";
    endcase
  endfunction

  function automatic logic [31:0] actual(int s);
    case (s)
      0: return 32'(spm_as_);   1: return 32'(spm_rw);
      2: return 32'(spm_addr);  3: return spm_wr_data;
      4: return 32'(mem_rdy_);  5: return 32'(dma_rdy_);
      6: return mem_rd_data;    7: return dma_rd_data;
      default: return 32'(m_wait);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(int'(a));
  endfunction

  always @(negedge clk) begin
    logic        e_as, e_rw, e_mrdy, e_drdy;
    logic [31:0] e_addr, e_wd, e_mrd, e_drd, rdv;
    int          win, nxt_owner;
    if (lit_cyc == cyc)
      for (int i = 0; i < lit_n; i++)
        chk({"lit_", sel_name(lit_sel[i])}, actual(lit_sel[i]), lit_exp[i]);
    e_as = 1'b1; e_rw = 1'b1; e_addr = '0; e_wd = '0;
    e_mrdy = 1'b1; e_drdy = 1'b1; e_mrd = '0; e_drd = '0;
    nxt_owner = 0;
    if (!reset_) begin
      m_wait = 0;
    end else if (m_owner != 0) begin
      rdv = m_rd ? model_read(m_addr) : 32'h0;
      if (m_owner == 1) begin e_mrdy = 1'b0; e_mrd = rdv; end
      else              begin e_drdy = 1'b0; e_drd = rdv; end
    end else begin
      if (!dma_as_ && (mem_as_ || m_wait >= LIM)) win = 2;
      else if (!mem_as_)                         win = 1;
      else                                       win = 0;
      if (win != 0) begin
        e_as   = 1'b0;
        e_rw   = (win == 1) ? mem_rw : dma_rw;
        e_addr = 32'((win == 1) ? mem_addr : dma_addr);
        e_wd   = (win == 1) ? mem_wr_data : dma_wr_data;
        m_rd   = e_rw;
        m_addr = AW'(e_addr);
        if (!e_rw) shadow[int'(e_addr)] = e_wd;
        nxt_owner = win;
      end
      if (win == 2) m_wait = 0;
      else if (win == 1 && !dma_as_ && m_wait < LIM) m_wait = m_wait + 1;
    end
    chk("spm_as_", 32'(spm_as_), 32'(e_as));
    chk("spm_rw", 32'(spm_rw), 32'(e_rw));
    chk("spm_addr", 32'(spm_addr), e_addr);
    chk("spm_wr_data", spm_wr_data, e_wd);
    chk("mem_rdy_", 32'(mem_rdy_), 32'(e_mrdy));
    chk("dma_rdy_", 32'(dma_rdy_), 32'(e_drdy));
    chk("mem_rd_data", mem_rd_data, e_mrd);
    chk("dma_rd_data", dma_rd_data, e_drd);
    m_owner = nxt_owner;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input int s, input logic [31:0] v);
    if (lit_cyc != cyc) begin
      lit_n   = 0;
      lit_cyc = cyc;
    end
    lit_sel[lit_n] = s;
    lit_exp[lit_n] = v;
    lit_n++;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] v;
    v = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) v = v | 12'hFF0;
    return v;
  endfunction

  initial begin
    bit m_act, d_act, m_done, d_done;
    int p_mem;
    // Reset with both requesters asserting: outputs must stay at reset values.
    reset_ = 1'b0;
    mem_as_ = 1'b0; mem_addr = 12'h055; mem_rw = 1'b0; mem_wr_data = 32'hAAAA5555;
    dma_as_ = 1'b0; dma_addr = 12'h0AA; dma_rw = 1'b0; dma_wr_data = 32'h5555AAAA;
    expect_lit(0, 1); expect_lit(1, 1); expect_lit(2, 0); expect_lit(3, 0);
    expect_lit(4, 1); expect_lit(5, 1); expect_lit(6, 0); expect_lit(7, 0);
    tick(); tick();
    mem_as_ = 1'b1; dma_as_ = 1'b1;
    tick();
    reset_ = 1'b1;
    tick();

    // MEM read of 0x010.
    mem_as_ = 1'b0; mem_addr = 12'h010; mem_rw = 1'b1;
    expect_lit(0, 0); expect_lit(2, 32'h010); expect_lit(1, 1);
    tick();
    expect_lit(4, 0); expect_lit(6, 32'hDEADBEEF); expect_lit(0, 1);
    tick();
    mem_as_ = 1'b1;
    expect_lit(0, 1); expect_lit(4, 1);
    tick();

    // DMA write then read-back of 0x7FF.
    dma_as_ = 1'b0; dma_addr = 12'h7FF; dma_rw = 1'b0; dma_wr_data = 32'h12345678;
    expect_lit(0, 0); expect_lit(1, 0); expect_lit(2, 32'h7FF); expect_lit(3, 32'h12345678);
    tick();
    expect_lit(5, 0); expect_lit(7, 0);
    tick();
    dma_rw = 1'b1; dma_wr_data = 32'h0;
    expect_lit(0, 0); expect_lit(1, 1); expect_lit(5, 1);
    tick();
    expect_lit(5, 0); expect_lit(7, 32'h12345678);
    tick();
    dma_as_ = 1'b1;
    tick();

    // Simultaneous single requests: MEM first, DMA at the next IDLE.
    mem_as_ = 1'b0; mem_addr = 12'h020; mem_rw = 1'b1;
    dma_as_ = 1'b0; dma_addr = 12'h030; dma_rw = 1'b1;
    expect_lit(2, 32'h020); expect_lit(5, 1);
    tick();
    expect_lit(4, 0); expect_lit(5, 1); expect_lit(0, 1); expect_lit(8, 1);
    tick();
    mem_as_ = 1'b1;
    expect_lit(0, 0); expect_lit(2, 32'h030);
    tick();
    expect_lit(5, 0); expect_lit(4, 1); expect_lit(8, 0);
    tick();
    dma_as_ = 1'b1;
    tick();

    // Continuous MEM traffic: DMA wins the 9th arbitration.
    mem_as_ = 1'b0; mem_addr = 12'h100; mem_rw = 1'b1;
    dma_as_ = 1'b0; dma_addr = 12'h200; dma_rw = 1'b1;
    for (int k = 0; k < 9; k++) begin
      expect_lit(0, 0); expect_lit(2, (k < 8) ? 32'h100 : 32'h200);
      tick();
      if (k < 8) begin expect_lit(4, 0); expect_lit(5, 1); end
      else       begin expect_lit(5, 0); expect_lit(4, 1); end
      if (k == 7) expect_lit(8, LIM);
      tick();
    end
    dma_as_ = 1'b1;
    expect_lit(2, 32'h100); expect_lit(8, 0); expect_lit(0, 0);
    tick();
    expect_lit(4, 0);
    tick();
    mem_as_ = 1'b1;
    tick();

    // Reset during MEM_RSP abandons the access; the held request is re-served.
    mem_as_ = 1'b0; mem_addr = 12'h010; mem_rw = 1'b1;
    expect_lit(2, 32'h010);
    tick();
    reset_ = 1'b0;
    expect_lit(4, 1); expect_lit(6, 0); expect_lit(0, 1);
    tick();
    expect_lit(4, 1);
    tick();
    reset_ = 1'b1;
    expect_lit(0, 0); expect_lit(2, 32'h010);
    tick();
    expect_lit(4, 0); expect_lit(6, 32'hDEADBEEF);
    tick();
    mem_as_ = 1'b1;
    tick();

    // Randomized traffic obeying the hold-until-rdy_ protocol, with occasional resets.
    m_act = 1'b0; d_act = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      m_done = !mem_rdy_;
      d_done = !dma_rdy_;
      @(posedge clk);
      #1;
      p_mem = (i < 2000) ? 5 : 9;
      if (!reset_) reset_ = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_ = 1'b0;
      if (!m_act || m_done) begin
        m_act       = ($urandom_range(0, 9) < p_mem);
        mem_as_     = !m_act;
        mem_addr    = rnd_addr();
        mem_rw      = 1'($urandom);
        mem_wr_data = $urandom;
      end
      if (!d_act || d_done) begin
        d_act       = ($urandom_range(0, 9) < 6);
        dma_as_     = !d_act;
        dma_addr    = rnd_addr();
        dma_rw      = 1'($urandom);
        dma_wr_data = $urandom;
      end
    end
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
